dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It sits on the memory side of the MEM stage, replacing the zero-latency data array. It also drives a stall signal, merged into the pipeline freeze, until each request has been answered. Requests are handled strictly one at a time with a fixed, parameterised access latency and address range checking.

---
 rtl/dmem_responder_if.sv | 38 +++
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ============================================================================
// dmem_responder_if : MEM-stage request/response bundle for dmem_responder
// Rev 1.0 : initial release (req_be present only with DMEM_BYTE_EN)
// ============================================================================
`default_nettype none

interface dmem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef DMEM_BYTE_EN
   logic [3:0]  req_be;
`endif
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;

   modport master (
`ifdef DMEM_BYTE_EN
      output req_be,
`endif
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );

   modport slave (
`ifdef DMEM_BYTE_EN
      input  req_be,
`endif
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : fixed-latency, one-at-a-time data-memory responder with
//                  range/alignment checking; DMEM_BYTE_EN adds byte-enabled stores
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned LATENCY     = 2
) (
   input wire              clk,
   input wire              rst,
   dmem_responder_if.slave bus
);

   localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [c_CNT_W-1:0]   cnt_q, cnt_d;
   logic                 we_q;
   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
`ifdef DMEM_BYTE_EN
   logic [3:0]           be_q;
   logic [3:0]           w_be;
`endif
   logic [31:0]          rdata_q;
   logic                 err_q;
   logic [31:0]          mem_q [DEPTH_WORDS];

   logic                 w_accept;
   logic                 w_enter_resp;
   logic                 w_we;
   logic [31:0]          w_addr;
   logic [31:0]          w_wdata;
   logic [31:0]          w_off;
   logic                 w_err;
   logic [c_IDX_W-1:0]   w_idx;
   logic [31:0]          w_rd_word;
   logic [31:0]          w_wr_word;

   // With LATENCY==1 the access happens on the accept edge, so the live request
   // must be used before it has been latched.
   always_comb begin
      if (state_q == S_IDLE) begin
         w_we    = bus.req_we;
         w_addr  = bus.req_addr;
         w_wdata = bus.req_wdata;
      end else begin
         w_we    = we_q;
         w_addr  = addr_q;
         w_wdata = wdata_q;
      end
   end

`ifdef DMEM_BYTE_EN
   assign w_be = (state_q == S_IDLE) ? bus.req_be : be_q;
`endif

   // Below-base addresses wrap in w_off, but the explicit compare flags them first.
   assign w_off = w_addr - BASE_ADDR;
   assign w_err = (w_addr < BASE_ADDR) ||
                  ((w_off >> 2) >= 32'(DEPTH_WORDS)) ||
                  (w_addr[1:0] != 2'b00);
   assign w_idx = c_IDX_W'(w_off >> 2);

   assign w_rd_word = mem_q[w_idx];

   always_comb begin
      w_wr_word = w_wdata;
`ifdef DMEM_BYTE_EN
      for (int b = 0; b < 4; b++) begin
         if (!w_be[b]) begin
            w_wr_word[8*b +: 8] = w_rd_word[8*b +: 8];
         end
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      w_accept     = 1'b0;
      w_enter_resp = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  state_d      = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = c_CNT_W'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == c_CNT_W'(1)) begin
               state_d      = S_RESP;
               w_enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef DMEM_BYTE_EN
         be_q    <= '0;
`endif
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (w_accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`ifdef DMEM_BYTE_EN
            be_q    <= bus.req_be;
`endif
         end
         if (w_enter_resp) begin
            err_q <= w_err;
            if (w_err) begin
               rdata_q <= '0;
            end else if (!w_we) begin
               rdata_q <= w_rd_word;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else if (w_enter_resp && w_we && !w_err) begin
         mem_q[w_idx] <= w_wr_word;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.stall     = bus.req_valid & ~bus.rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed scoreboard bench for dmem_responder (LATENCY 2 and 1)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];
   logic [31:0] mdl [2][256];
   logic [31:0] last_rdata [2];

   dmem_responder_if if_a ();
   dmem_responder_if if_b ();

   dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'd1024), .LATENCY(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'd1024), .LATENCY(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic o_ready(input int d);
      return (d == 0) ? if_a.req_ready : if_b.req_ready;
   endfunction
   function automatic logic o_valid(input int d);
      return (d == 0) ? if_a.rsp_valid : if_b.rsp_valid;
   endfunction
   function automatic logic o_stall(input int d);
      return (d == 0) ? if_a.stall : if_b.stall;
   endfunction
   function automatic logic o_err(input int d);
      return (d == 0) ? if_a.rsp_err : if_b.rsp_err;
   endfunction
   function automatic logic [31:0] o_rdata(input int d);
      return (d == 0) ? if_a.rsp_rdata : if_b.rsp_rdata;
   endfunction

   task automatic set_req(input int d, input logic v, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
      if (d == 0) begin
         if_a.req_valid = v; if_a.req_we = we; if_a.req_addr = addr; if_a.req_wdata = wdata;
`ifdef DMEM_BYTE_EN
         if_a.req_be = be;
`endif
      end else begin
         if_b.req_valid = v; if_b.req_we = we; if_b.req_addr = addr; if_b.req_wdata = wdata;
`ifdef DMEM_BYTE_EN
         if_b.req_be = be;
`endif
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) mdl[d][i] = '0;
         last_rdata[d] = '0;
      end
   endtask

   // Reference behaviour of one request; the expected response goes on the scoreboard.
   task automatic model_req(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
      exp_t        e;
      logic [31:0] off;
      logic [31:0] word;
      bit          err;
      int          idx;
      off = addr - 32'd1024;
      err = (addr < 32'd1024) || ((off >> 2) >= 32'd256) || (addr[1:0] != 2'b00);
      idx = int'(off >> 2);
      if (err) begin
         last_rdata[d] = '0;
         e.err = 1'b1;
      end else if (we) begin
         word = mdl[d][idx];
`ifdef DMEM_BYTE_EN
         for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
`else
         word = wdata;
`endif
         mdl[d][idx] = word;
         e.err = 1'b0;
      end else begin
         last_rdata[d] = mdl[d][idx];
         e.err = 1'b0;
      end
      e.rdata = last_rdata[d];
      sb.push_back(e);
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after the response.
   task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output time t_acc);
      exp_t        e;
      int          n;
      bit          got;
      logic [31:0] prev;
      prev = last_rdata[d];
      model_req(d, we, addr, wdata, be);
      set_req(d, 1'b1, we, addr, wdata, be);
      @(negedge clk);
      check("ready_idle", 32'(o_ready(d)), 32'd1);
      check("stall_req", 32'(o_stall(d)), 32'd1);
      @(posedge clk);
      t_acc = $time;
      n = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (o_valid(d)) begin
            got = 1;
         end else begin
            check("ready_wait", 32'(o_ready(d)), 32'd0);
            check("stall_wait", 32'(o_stall(d)), 32'd1);
            check("rdata_hold", o_rdata(d), prev);
         end
      end
      check("rsp_seen", 32'(got), 32'd1);
      check("latency", 32'(n), (d == 0) ? 32'd2 : 32'd1);
      e = sb.pop_front();
      if (got) begin
         check("rsp_rdata", o_rdata(d), e.rdata);
         check("rsp_err", 32'(o_err(d)), 32'(e.err));
         check("ready_resp", 32'(o_ready(d)), 32'd0);
         check("stall_resp", 32'(o_stall(d)), 32'd0);
      end
      @(posedge clk);
      #1;
      set_req(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      time t0, t1;
      checks = 0;
      errors = 0;
      model_reset();
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_ready", 32'(if_a.req_ready), 32'd1);
      check("rst_valid", 32'(if_a.rsp_valid), 32'd0);
      check("rst_rdata", if_a.rsp_rdata, 32'd0);
      check("rst_err", 32'(if_a.rsp_err), 32'd0);
      check("rst_stall", 32'(if_a.stall), 32'd0);
      check("rst_ready_b", 32'(if_b.req_ready), 32'd1);
      @(posedge clk);
      #1;

      do_req(0, 1'b0, 32'd1024, 32'd0, 4'hF, t0);
      do_req(0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'hF, t0);
      do_req(0, 1'b0, 32'd1028, 32'd0, 4'hF, t0);
      do_req(0, 1'b0, 32'd1020, 32'd0, 4'hF, t0);
      do_req(0, 1'b0, 32'd2048, 32'd0, 4'hF, t0);
      do_req(0, 1'b0, 32'd2044, 32'd0, 4'hF, t0);
      do_req(0, 1'b1, 32'd1024, 32'h5A5A0001, 4'hF, t0);
      do_req(0, 1'b1, 32'd1026, 32'hFFFFFFFF, 4'hF, t0);
      do_req(0, 1'b0, 32'd1024, 32'd0, 4'hF, t0);
      do_req(0, 1'b0, 32'd1028, 32'd0, 4'hF, t0);

      // Reset lands while the store is waiting; it must neither write nor respond.
      set_req(0, 1'b1, 1'b1, 32'd1032, 32'h12345678, 4'hF);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("wait_before_rst", 32'(if_a.req_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_rsp_after_rst", 32'(if_a.rsp_valid), 32'd0);
      end
      check("rdata_after_rst", if_a.rsp_rdata, 32'd0);
      check("ready_after_rst", 32'(if_a.req_ready), 32'd1);
      @(posedge clk);
      #1;
      do_req(0, 1'b0, 32'd1032, 32'd0, 4'hF, t0);

      do_req(1, 1'b1, 32'd1024, 32'h11111111, 4'hF, t0);
      do_req(1, 1'b1, 32'd1028, 32'h22222222, 4'hF, t0);
      do_req(1, 1'b0, 32'd1024, 32'd0, 4'hF, t0);
      do_req(1, 1'b0, 32'd1028, 32'd0, 4'hF, t1);
      check("accept_spacing", 32'((t1 - t0) / 10), 32'd2);

`ifdef DMEM_BYTE_EN
      do_req(0, 1'b1, 32'd1040, 32'hAABBCCDD, 4'hF, t0);
      do_req(0, 1'b1, 32'd1040, 32'h00000011, 4'h1, t0);
      do_req(0, 1'b1, 32'd1040, 32'hFFFFFFFF, 4'h0, t0);
      do_req(0, 1'b0, 32'd1040, 32'd0, 4'h0, t0);
`else
      do_req(0, 1'b1, 32'd1040, 32'hAABBCCDD, 4'hF, t0);
      do_req(0, 1'b1, 32'd1040, 32'h00000011, 4'h1, t0);
      do_req(0, 1'b0, 32'd1040, 32'd0, 4'h0, t0);
`endif

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
